// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// No logic of its own; latency and backpressure are defined by the users.
// Default vectors are 32 bits wide and truncated by the instantiating block.
package pc_sequencer_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_t;

    // Every instruction is one 32-bit word.
    localparam int unsigned INSTR_BYTES = 4;
    // Branch offsets and J-type indices are in words, not bytes.
    localparam int unsigned WORD_SHIFT  = 2;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_target_calc.sv
// Candidate next-PC values: PC+4, branch target, J-type target, branch condition.
// Purely combinational, zero latency.
// No flow control; outputs follow the inputs every cycle.
module pc_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] imm_ext_i,
    input  logic [25:0]      jump_idx_i,
    input  logic             branch_eq_i,
    input  logic             branch_ne_i,
    input  logic             alu_zero_i,
    output logic [WIDTH-1:0] pc_plus_4_o,
    output logic [WIDTH-1:0] pc_branch_o,
    output logic [WIDTH-1:0] jump_target_o,
    output logic             branch_taken_o
);

    // Sequential and PC-relative targets; carries out of the top bit are dropped.
    always_comb begin
        pc_plus_4_o    = pc_i + WIDTH'(INSTR_BYTES);
        pc_branch_o    = pc_plus_4_o + (imm_ext_i << WORD_SHIFT);
        branch_taken_o = (branch_eq_i & alu_zero_i) | (branch_ne_i & ~alu_zero_i);
    end

    // J-type target keeps the region bits of PC+4 above the 28-bit word span.
    generate
        if (WIDTH > 28) begin : g_region
            assign jump_target_o = {pc_plus_4_o[WIDTH-1:28], jump_idx_i, 2'b00};
        end else begin : g_no_region
            assign jump_target_o = {jump_idx_i, 2'b00};
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with next-PC selection, misaligned-target trap and transfer counter.
// One cycle from redirect inputs to pc_o; target outputs are combinational.
// stall_i holds PC, state and counter; redirect inputs must be held by their producer.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             branch_eq_i,
    input  logic             branch_ne_i,
    input  logic             alu_zero_i,
    input  logic [WIDTH-1:0] imm_ext_i,
    input  logic             jump_i,
    input  logic [25:0]      jump_idx_i,
    input  logic             jr_i,
    input  logic [WIDTH-1:0] jr_target_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus_4_o,
    output logic [WIDTH-1:0] pc_branch_o,
    output logic             branch_taken_o,
    output logic             trap_o,
    output logic [CNT_W-1:0] taken_count_o
);

    localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] next_pc;
    logic             transfer;

    pc_target_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .pc_i           (pc_q),
        .imm_ext_i      (imm_ext_i),
        .jump_idx_i     (jump_idx_i),
        .branch_eq_i    (branch_eq_i),
        .branch_ne_i    (branch_ne_i),
        .alu_zero_i     (alu_zero_i),
        .pc_plus_4_o    (pc_plus_4_o),
        .pc_branch_o    (pc_branch_o),
        .jump_target_o  (jump_target),
        .branch_taken_o (branch_taken_o)
    );

    // Next-PC priority, state transitions and saturating transfer count.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        transfer = jr_i | jump_i | branch_taken_o;

        if (jr_i) begin
            next_pc = jr_target_i;
        end else if (jump_i) begin
            next_pc = jump_target;
        end else if (branch_taken_o) begin
            next_pc = pc_branch_o;
        end else begin
            next_pc = pc_plus_4_o;
        end

        case (state_q)
            RUN: begin
                if (!stall_i) begin
                    // Only JR can deliver a misaligned target; a trapping transfer is not counted.
                    if (next_pc[1:0] != 2'b00) begin
                        pc_d    = TRAP_PC;
                        state_d = TRAP;
                    end else begin
                        pc_d = next_pc;
                        if (transfer && (cnt_q != {CNT_W{1'b1}})) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            TRAP: begin
                pc_d = TRAP_PC;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, PC and counter registers; reset wins in any state, including TRAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RST_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o          = pc_q;
    assign trap_o        = (state_q == TRAP);
    assign taken_count_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        branch_eq_i;
    logic        branch_ne_i;
    logic        alu_zero_i;
    logic [31:0] imm_ext_i;
    logic        jump_i;
    logic [25:0] jump_idx_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_4_o;
    logic [31:0] pc_branch_o;
    logic        branch_taken_o;
    logic        trap_o;
    logic [3:0]  taken_count_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic        trap;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad   = 0;
    logic [3:0]  exp_cnt;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0080),
        .CNT_W        (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .branch_eq_i    (branch_eq_i),
        .branch_ne_i    (branch_ne_i),
        .alu_zero_i     (alu_zero_i),
        .imm_ext_i      (imm_ext_i),
        .jump_i         (jump_i),
        .jump_idx_i     (jump_idx_i),
        .jr_i           (jr_i),
        .jr_target_i    (jr_target_i),
        .pc_o           (pc_o),
        .pc_plus_4_o    (pc_plus_4_o),
        .pc_branch_o    (pc_branch_o),
        .branch_taken_o (branch_taken_o),
        .trap_o         (trap_o),
        .taken_count_o  (taken_count_o)
    );

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    // Advance past the next rising edge so outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic beq, input logic bne, input logic z,
                         input logic [31:0] imm, input logic j, input logic [25:0] idx,
                         input logic r, input logic [31:0] tgt);
        stall_i     = st;
        branch_eq_i = beq;
        branch_ne_i = bne;
        alu_zero_i  = z;
        imm_ext_i   = imm;
        jump_i      = j;
        jump_idx_i  = idx;
        jr_i        = r;
        jr_target_i = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    // Move the PC with an aligned JR; this is a counted transfer.
    task automatic set_pc(input logic [31:0] a);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, a);
        exp_cnt = sat_inc(exp_cnt);
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h5, 1'b1, 26'h123, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
            total++;
            if (trap_o !== 1'b0) begin bad++; $display("FAIL reset_trap: got %b want 0", trap_o); end
            total++;
            if (taken_count_o !== 4'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", taken_count_o); end
        end
        idle();
        reset = 1'b0;
        exp_cnt = 4'h0;
        sb.push_back(exp_t'{pc: 32'h4, cnt: 4'h0, trap: 1'b0});
        sb.push_back(exp_t'{pc: 32'h8, cnt: 4'h0, trap: 1'b0});
        sb.push_back(exp_t'{pc: 32'hC, cnt: 4'h0, trap: 1'b0});
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            total++;
            if (pc_o !== e.pc) begin bad++; $display("FAIL idle_pc: got %h want %h", pc_o, e.pc); end
            total++;
            if (taken_count_o !== e.cnt) begin bad++; $display("FAIL idle_cnt: got %h want %h", taken_count_o, e.cnt); end
        end
    endtask

    task automatic test_branch_eq();
        set_pc(32'h0000_1000);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 26'h0, 1'b0, 32'h0);
        #1;
        total++;
        if (pc_plus_4_o !== 32'h0000_1004) begin bad++; $display("FAIL beq_plus4: got %h want %h", pc_plus_4_o, 32'h1004); end
        total++;
        if (pc_branch_o !== 32'h0000_1008) begin bad++; $display("FAIL beq_target: got %h want %h", pc_branch_o, 32'h1008); end
        total++;
        if (branch_taken_o !== 1'b1) begin bad++; $display("FAIL beq_taken: got %b want 1", branch_taken_o); end
        exp_cnt = sat_inc(exp_cnt);
        sb.push_back(exp_t'{pc: 32'h0000_1008, cnt: exp_cnt, trap: 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL beq_pc: got %h want %h", pc_o, e.pc); end
        total++;
        if (taken_count_o !== e.cnt) begin bad++; $display("FAIL beq_cnt: got %h want %h", taken_count_o, e.cnt); end
        idle();
    endtask

    task automatic test_branch_ne();
        set_pc(32'h0000_3008);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0);
        exp_cnt = sat_inc(exp_cnt);
        sb.push_back(exp_t'{pc: 32'h0000_2FFC, cnt: exp_cnt, trap: 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL bne_pc: got %h want %h", pc_o, e.pc); end
        total++;
        if (taken_count_o !== e.cnt) begin bad++; $display("FAIL bne_cnt: got %h want %h", taken_count_o, e.cnt); end

        set_pc(32'h0000_3008);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0);
        #1;
        total++;
        if (branch_taken_o !== 1'b0) begin bad++; $display("FAIL bne_not_taken: got %b want 0", branch_taken_o); end
        sb.push_back(exp_t'{pc: 32'h0000_300C, cnt: exp_cnt, trap: 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL bne_nt_pc: got %h want %h", pc_o, e.pc); end
        total++;
        if (taken_count_o !== e.cnt) begin bad++; $display("FAIL bne_nt_cnt: got %h want %h", taken_count_o, e.cnt); end
        idle();
    endtask

    task automatic test_priority();
        set_pc(32'h0040_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 26'h000_0010, 1'b0, 32'h0);
        exp_cnt = sat_inc(exp_cnt);
        sb.push_back(exp_t'{pc: 32'h0000_0040, cnt: exp_cnt, trap: 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL jump_pc: got %h want %h", pc_o, e.pc); end
        total++;
        if (taken_count_o !== e.cnt) begin bad++; $display("FAIL jump_cnt: got %h want %h", taken_count_o, e.cnt); end

        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 26'h000_0010, 1'b1, 32'h0000_2000);
        exp_cnt = sat_inc(exp_cnt);
        sb.push_back(exp_t'{pc: 32'h0000_2000, cnt: exp_cnt, trap: 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL jr_pc: got %h want %h", pc_o, e.pc); end
        total++;
        if (taken_count_o !== e.cnt) begin bad++; $display("FAIL jr_cnt: got %h want %h", taken_count_o, e.cnt); end
        idle();
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0100, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_t'{pc: 32'h0000_2000, cnt: exp_cnt, trap: 1'b0});
            tick();
            e = sb.pop_front();
            total++;
            if (pc_o !== e.pc) begin bad++; $display("FAIL stall_pc: got %h want %h", pc_o, e.pc); end
            total++;
            if (taken_count_o !== e.cnt) begin bad++; $display("FAIL stall_cnt: got %h want %h", taken_count_o, e.cnt); end
            total++;
            if (pc_plus_4_o !== 32'h0000_2004) begin bad++; $display("FAIL stall_plus4: got %h want %h", pc_plus_4_o, 32'h2004); end
        end
        stall_i = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        sb.push_back(exp_t'{pc: 32'h0000_0400, cnt: exp_cnt, trap: 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL unstall_pc: got %h want %h", pc_o, e.pc); end
        total++;
        if (taken_count_o !== e.cnt) begin bad++; $display("FAIL unstall_cnt: got %h want %h", taken_count_o, e.cnt); end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_2002);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_t'{pc: 32'h0000_0400, cnt: exp_cnt, trap: 1'b0});
            tick();
            e = sb.pop_front();
            total++;
            if (pc_o !== e.pc) begin bad++; $display("FAIL stall_jr_pc: got %h want %h", pc_o, e.pc); end
            total++;
            if (trap_o !== e.trap) begin bad++; $display("FAIL stall_jr_trap: got %b want %b", trap_o, e.trap); end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        tick();
        idle();
        sb.push_back(exp_t'{pc: 32'h0000_0404, cnt: exp_cnt, trap: 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL stall_idle_pc: got %h want %h", pc_o, e.pc); end
    endtask

    task automatic test_trap();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_2002);
        sb.push_back(exp_t'{pc: 32'h0000_0080, cnt: exp_cnt, trap: 1'b1});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL trap_pc: got %h want %h", pc_o, e.pc); end
        total++;
        if (trap_o !== e.trap) begin bad++; $display("FAIL trap_flag: got %b want %b", trap_o, e.trap); end
        total++;
        if (taken_count_o !== e.cnt) begin bad++; $display("FAIL trap_cnt: got %h want %h", taken_count_o, e.cnt); end

        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 26'h5, 1'b1, 32'h0000_3000);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_t'{pc: 32'h0000_0080, cnt: exp_cnt, trap: 1'b1});
            tick();
            e = sb.pop_front();
            total++;
            if (pc_o !== e.pc) begin bad++; $display("FAIL trap_hold_pc: got %h want %h", pc_o, e.pc); end
            total++;
            if (trap_o !== e.trap) begin bad++; $display("FAIL trap_hold_flag: got %b want %b", trap_o, e.trap); end
            total++;
            if (taken_count_o !== e.cnt) begin bad++; $display("FAIL trap_hold_cnt: got %h want %h", taken_count_o, e.cnt); end
        end

        // Reset pulse strictly between rising edges.
        idle();
        #1 reset = 1'b1;
        #1;
        total++;
        if (pc_o !== 32'h0) begin bad++; $display("FAIL async_pc: got %h want %h", pc_o, 32'h0); end
        total++;
        if (trap_o !== 1'b0) begin bad++; $display("FAIL async_trap: got %b want 0", trap_o); end
        total++;
        if (taken_count_o !== 4'h0) begin bad++; $display("FAIL async_cnt: got %h want 0", taken_count_o); end
        #1 reset = 1'b0;
        exp_cnt = 4'h0;
        sb.push_back(exp_t'{pc: 32'h0000_0004, cnt: 4'h0, trap: 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if (pc_o !== e.pc) begin bad++; $display("FAIL post_reset_pc: got %h want %h", pc_o, e.pc); end
    endtask

    // Even steps use BEQ, odd steps raise BEQ and BNE together with zero low.
    task automatic test_saturation();
        exp_pc = 32'h0000_0004;
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0) begin
                drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 26'h0, 1'b0, 32'h0);
            end else begin
                drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 26'h0, 1'b0, 32'h0);
            end
            exp_pc  = exp_pc + 32'd8;
            exp_cnt = sat_inc(exp_cnt);
            sb.push_back(exp_t'{pc: exp_pc, cnt: exp_cnt, trap: 1'b0});
            tick();
            e = sb.pop_front();
            total++;
            if (pc_o !== e.pc) begin bad++; $display("FAIL sat_pc[%0d]: got %h want %h", i, pc_o, e.pc); end
            total++;
            if (taken_count_o !== e.cnt) begin bad++; $display("FAIL sat_cnt[%0d]: got %h want %h", i, taken_count_o, e.cnt); end
        end
        idle();
        total++;
        if (taken_count_o !== 4'hF) begin bad++; $display("FAIL sat_final: got %h want F", taken_count_o); end
    endtask

    initial begin
        reset   = 1'b1;
        exp_cnt = 4'h0;
        exp_pc  = 32'h0;
        idle();
        test_reset();
        test_branch_eq();
        test_branch_ne();
        test_priority();
        test_stall();
        test_trap();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
